// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Next-address stage feeding the program counter's parallel load input.
//   Selects, in priority order, stall / return / call / jump / branch /
//   sequential increment, and keeps a small return-address stack (RAS)
//   for call/return with sticky overflow/underflow flags.
//
// Ports
//   clock_reg      : clock, state updates on rising edge
//   reset          : asynchronous, active-low clear of all state
//   pc             : current program counter value
//   stall          : hold pc, no stack change
//   branch_taken   : relative branch, target = pc + 1 + branch_offset
//   branch_offset  : two's-complement branch offset
//   jump           : absolute jump to jump_addr
//   call           : push pc + 1, go to jump_addr
//   ret            : pop RAS top into pc_next
//   jump_addr      : absolute target for jump/call
//   clear_err      : synchronous clear of sticky flags
//   pc_next        : combinational next PC
//   ras_count      : valid RAS entries (0..DEPTH)
//   ras_full       : ras_count == DEPTH
//   ras_empty      : ras_count == 0
//   overflow       : sticky, call attempted with RAS full
//   underflow      : sticky, return attempted with RAS empty

module pc_next_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = 2
) (
    input  logic             clock_reg,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             clear_err,
    output logic [WIDTH-1:0] pc_next,
    output logic [SPW:0]     ras_count,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] ras_mem [DEPTH];
    logic [SPW:0]     count_q;
    logic             overflow_q;
    logic             underflow_q;

    logic [WIDTH-1:0] inc;
    logic [SPW:0]     top_tmp;
    logic [SPW-1:0]   top_idx;
    logic [SPW-1:0]   push_idx;
    logic             is_empty;
    logic             is_full;

    logic             do_push;
    logic             do_pop;
    logic             set_ovf;
    logic             set_unf;

    assign inc      = pc + WIDTH'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (SPW+1)'(DEPTH));

    // Top entry lives at count-1; only meaningful when non-empty. The next
    // free slot is count itself, which fits in SPW bits whenever not full.
    assign top_tmp  = count_q - (SPW+1)'(1);
    assign top_idx  = top_tmp[SPW-1:0];
    assign push_idx = count_q[SPW-1:0];

    always_comb begin
        pc_next = inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (stall) begin
            pc_next = pc;
        end else if (ret) begin
            if (is_empty) begin
                pc_next = inc;
                set_unf = 1'b1;
            end else begin
                pc_next = ras_mem[top_idx];
                do_pop  = 1'b1;
            end
        end else if (call) begin
            pc_next = jump_addr;
            if (is_full) begin
                set_ovf = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end else if (jump) begin
            pc_next = jump_addr;
        end else if (branch_taken) begin
            pc_next = inc + branch_offset;
        end
    end

    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                ras_mem[push_idx] <= inc;
                count_q           <= count_q + (SPW+1)'(1);
            end else if (do_pop) begin
                count_q <= top_tmp;
            end
            // A new error in the same cycle as clear_err keeps the flag set.
            overflow_q  <= set_ovf | (overflow_q  & ~clear_err);
            underflow_q <= set_unf | (underflow_q & ~clear_err);
        end
    end

    assign ras_count = count_q;
    assign ras_full  = is_full;
    assign ras_empty = is_empty;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed testbench for pc_next_unit with a queue-based scoreboard.
// Stimulus pushes expected values; a monitor pops and compares them when
// the stimulus signals that the DUT outputs are ready to sample.

module tb_pc_next_unit;

    logic       clock_reg;
    logic       reset;
    logic [7:0] pc;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic       jump;
    logic       call;
    logic       ret;
    logic [7:0] jump_addr;
    logic       clear_err;
    logic [7:0] pc_next;
    logic [2:0] ras_count;
    logic       ras_full;
    logic       ras_empty;
    logic       overflow;
    logic       underflow;

    pc_next_unit #(.WIDTH(8), .DEPTH(4), .SPW(2)) dut (
        .clock_reg     (clock_reg),
        .reset         (reset),
        .pc            (pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_addr     (jump_addr),
        .clear_err     (clear_err),
        .pc_next       (pc_next),
        .ras_count     (ras_count),
        .ras_full      (ras_full),
        .ras_empty     (ras_empty),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial clock_reg = 1'b0;
    always #5 clock_reg = ~clock_reg;

    localparam int S_PCN = 0;
    localparam int S_CNT = 1;
    localparam int S_FUL = 2;
    localparam int S_EMP = 3;
    localparam int S_OVF = 4;
    localparam int S_UNF = 5;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
    } item_t;

    item_t sb[$];
    event  chk_ev;
    int    n_checks = 0;
    int    n_err    = 0;

    initial begin
        item_t      it;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                it = sb.pop_front();
                case (it.sel)
                    S_PCN:   act = pc_next;
                    S_CNT:   act = {5'b0, ras_count};
                    S_FUL:   act = {7'b0, ras_full};
                    S_EMP:   act = {7'b0, ras_empty};
                    S_OVF:   act = {7'b0, overflow};
                    default: act = {7'b0, underflow};
                endcase
                n_checks++;
                if (act !== it.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                             it.name, act, it.val, $time);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] p, input logic st, input logic br,
                         input logic [7:0] off, input logic jp, input logic cl,
                         input logic rt, input logic [7:0] ja, input logic clr);
        @(negedge clock_reg);
        pc            = p;
        stall         = st;
        branch_taken  = br;
        branch_offset = off;
        jump          = jp;
        call          = cl;
        ret           = rt;
        jump_addr     = ja;
        clear_err     = clr;
    endtask

    task automatic idle(input logic [7:0] p);
        drive(p, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic chk(input string n, input int s, input logic [7:0] v);
        sb.push_back('{n, s, v});
    endtask

    task automatic fire;
        #1;
        -> chk_ev;
    endtask

    initial begin
        logic [7:0] ret_exp [4];
        ret_exp[0] = 8'h05; ret_exp[1] = 8'h04;
        ret_exp[2] = 8'h03; ret_exp[3] = 8'h02;

        reset = 1'b0;
        pc = 8'h10; stall = 0; branch_taken = 0; branch_offset = 8'h00;
        jump = 0; call = 0; ret = 0; jump_addr = 8'h00; clear_err = 0;

        // In reset: combinational path still live, state cleared.
        #12;
        chk("rst_pcn", S_PCN, 8'h11);
        chk("rst_cnt", S_CNT, 8'd0);
        chk("rst_emp", S_EMP, 8'd1);
        chk("rst_ful", S_FUL, 8'd0);
        chk("rst_ovf", S_OVF, 8'd0);
        chk("rst_unf", S_UNF, 8'd0);
        fire();

        @(negedge clock_reg);
        reset = 1'b1;

        idle(8'h10);
        chk("inc_10", S_PCN, 8'h11);
        fire();
        idle(8'hFF);
        chk("inc_wrap", S_PCN, 8'h00);
        chk("idle_emp", S_EMP, 8'd1);
        fire();

        drive(8'h20, 0, 1, 8'hFE, 0, 0, 0, 8'h00, 0);
        chk("branch_neg", S_PCN, 8'h1F);
        fire();
        drive(8'h20, 1, 1, 8'hFE, 0, 0, 0, 8'h00, 0);
        chk("stall_branch", S_PCN, 8'h20);
        fire();
        drive(8'h10, 0, 1, 8'h05, 1, 0, 0, 8'h77, 0);
        chk("jump_over_branch", S_PCN, 8'h77);
        fire();
        drive(8'h10, 0, 1, 8'h05, 0, 0, 0, 8'h00, 0);
        chk("branch_pos", S_PCN, 8'h16);
        chk("jump_no_push", S_CNT, 8'd0);
        fire();

        // Single call / return
        drive(8'h05, 0, 0, 8'h00, 0, 1, 0, 8'h80, 0);
        chk("call_tgt", S_PCN, 8'h80);
        fire();
        idle(8'h80);
        chk("call_cnt", S_CNT, 8'd1);
        chk("call_nemp", S_EMP, 8'd0);
        fire();
        drive(8'h80, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0);
        chk("ret_tgt", S_PCN, 8'h06);
        fire();
        idle(8'h06);
        chk("ret_cnt", S_CNT, 8'd0);
        chk("ret_emp", S_EMP, 8'd1);
        fire();

        // Fill and overflow
        for (int i = 1; i <= 5; i++) begin
            drive(8'(i), 0, 0, 8'h00, 0, 1, 0, 8'h40, 0);
            chk("fill_tgt", S_PCN, 8'h40);
            chk("fill_cnt", S_CNT, 8'(i - 1 > 4 ? 4 : i - 1));
            chk("fill_ovf_pre", S_OVF, 8'd0);
            fire();
        end
        drive(8'h40, 1, 0, 8'h00, 0, 0, 1, 8'h00, 0);
        chk("ovf_set", S_OVF, 8'd1);
        chk("full_set", S_FUL, 8'd1);
        chk("full_cnt", S_CNT, 8'd4);
        chk("stall_ret", S_PCN, 8'h40);
        fire();
        for (int i = 0; i < 4; i++) begin
            drive(8'h40, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0);
            chk("stall_no_pop", S_CNT, 8'(4 - i));
            chk("ret_order", S_PCN, ret_exp[i]);
            fire();
        end
        idle(8'h02);
        chk("drain_cnt", S_CNT, 8'd0);
        chk("drain_emp", S_EMP, 8'd1);
        chk("ovf_sticky", S_OVF, 8'd1);
        fire();

        // Underflow, clear, and set-wins-over-clear
        drive(8'h30, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0);
        chk("unf_tgt", S_PCN, 8'h31);
        fire();
        idle(8'h31);
        chk("unf_set", S_UNF, 8'd1);
        chk("unf_cnt", S_CNT, 8'd0);
        fire();
        drive(8'h31, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1);
        idle(8'h32);
        chk("clr_unf", S_UNF, 8'd0);
        chk("clr_ovf", S_OVF, 8'd0);
        fire();
        drive(8'h30, 0, 0, 8'h00, 0, 0, 1, 8'h00, 1);
        idle(8'h31);
        chk("set_wins", S_UNF, 8'd1);
        fire();

        // Mid-cycle async reset
        drive(8'h10, 0, 0, 8'h00, 0, 1, 0, 8'h50, 0);
        drive(8'h50, 0, 0, 8'h00, 0, 1, 0, 8'h60, 0);
        idle(8'h60);
        chk("pre_rst_cnt", S_CNT, 8'd2);
        chk("pre_rst_unf", S_UNF, 8'd1);
        fire();
        #1;
        reset = 1'b0;
        #1;
        chk("async_cnt", S_CNT, 8'd0);
        chk("async_unf", S_UNF, 8'd0);
        chk("async_emp", S_EMP, 8'd1);
        fire();
        @(negedge clock_reg);
        reset = 1'b1;

        // Call + ret together with one entry: pop only
        drive(8'h10, 0, 0, 8'h00, 0, 1, 0, 8'h50, 0);
        drive(8'h50, 0, 0, 8'h00, 0, 1, 1, 8'h70, 0);
        chk("callret_cnt_pre", S_CNT, 8'd1);
        chk("callret_tgt", S_PCN, 8'h11);
        fire();
        idle(8'h11);
        chk("callret_cnt", S_CNT, 8'd0);
        chk("callret_ovf", S_OVF, 8'd0);
        fire();

        #5;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Next-address stage that sits directly upstream of the 8-bit program counter register.
- Each cycle it computes the value the program counter loads on the next clock_reg edge (pc_next drives the PC's parallel input).
- Supported flows: sequential increment, relative branch, absolute jump, call and return.
- Holds a small hardware return-address stack (RAS) for call/return, with sticky error flags.

Parameters:
- WIDTH, 8, address width in bits; all address arithmetic is modulo 2^WIDTH.
- DEPTH, 4, number of RAS entries; must be a power of two, at least 2.
- SPW, 2, RAS pointer width; equals log2(DEPTH).

Ports:
- clock_reg  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- pc  in  WIDTH  current program counter value (the PC register output).
- stall  in  1  hold: pc_next = pc; no stack change.
- branch_taken  in  1  conditional branch resolved taken.
- branch_offset  in  WIDTH  two's-complement offset, relative to pc+1.
- jump  in  1  absolute jump.
- call  in  1  subroutine call; target is jump_addr.
- ret  in  1  subroutine return.
- jump_addr  in  WIDTH  absolute target for jump and call.
- clear_err  in  1  synchronous clear of the sticky error flags.
- pc_next  out  WIDTH  address for the PC to load (combinational).
- ras_count  out  SPW+1  number of valid RAS entries (0..DEPTH).
- ras_full  out  1  ras_count == DEPTH.
- ras_empty  out  1  ras_count == 0.
- overflow  out  1  sticky: a call was attempted while the RAS was full.
- underflow  out  1  sticky: a return was attempted while the RAS was empty.

Behaviour:
- Reset (reset low, asynchronous):
  - ras_count = 0, overflow = 0, underflow = 0, all RAS entries cleared to 0.
  - ras_empty = 1, ras_full = 0.
  - pc_next is still driven combinationally from the inputs while reset is low.
- Arithmetic: inc = pc + 1, truncated to WIDTH (so 0xFF -> 0x00). Branch target = inc + branch_offset, truncated to WIDTH.
- Priority, highest first; exactly one action applies per cycle:
  1. stall: pc_next = pc; no stack or flag update. clear_err is still honoured.
  2. ret:
     - If RAS is non-empty: pc_next = top entry; pop (ras_count - 1).
     - If RAS is empty: pc_next = inc; underflow <= 1; no pop.
  3. call:
     - pc_next = jump_addr.
     - If RAS is not full: push inc (ras_count + 1).
     - If RAS is full: overflow <= 1; push discarded; RAS contents unchanged.
  4. jump: pc_next = jump_addr.
  5. branch_taken: pc_next = inc + branch_offset.
  6. Otherwise: pc_next = inc.
- Latency:
  - pc_next is combinational: zero cycles from the inputs and from the current RAS top.
  - Stack push/pop and flag updates take effect at the next rising edge of clock_reg.
- Call and ret asserted together: ret wins; call is ignored that cycle.
- The RAS is LIFO with a single top pointer; the top entry is the most recent successful push.
- Sticky flags:
  - Set as described above; hold until clear_err or reset.
  - If clear_err and a new error occur in the same cycle, the set wins.
- Reset mid-operation: state is cleared immediately; any in-flight push or pop is lost.

Test Plan:
- Reset, then stall=0 with no controls, pc=0x10 -> pc_next=0x11; pc=0xFF -> pc_next=0x00; ras_empty=1, ras_count=0.
- pc=0x20, branch_taken=1, branch_offset=0xFE -> pc_next=0x1F; with stall=1 and branch_taken=1 -> pc_next=0x20.
- pc=0x05, call=1, jump_addr=0x80 -> pc_next=0x80, then ras_count=1 after the edge; later ret=1 -> pc_next=0x06, then ras_count=0 after the edge.
- Five calls from pc=0x01..0x05 with DEPTH=4 -> overflow=1 after the fifth, ras_full=1. Four rets then return 0x05, 0x04, 0x03, 0x02 in that order.
- ret with the RAS empty at pc=0x30 -> pc_next=0x31, underflow=1. clear_err=1 for one cycle -> underflow=0.
- Push two entries, assert reset low mid-cycle -> ras_count=0, flags=0 immediately. Call and ret together with 1 entry -> pop only, ras_count=0.
